// File: rtl/mem_alu_seq.sv
// ============================================================================
// Module  : mem_alu_seq
// Brief   : Handshaked 3-address memory-to-memory ALU over a 2^ADDR_W x DATA_W
//           register file. Define MEM_ALU_MULDIV_EN to build ops 13-15
//           (multiply and the iterative restoring divider).
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module mem_alu_seq #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 4,
  localparam int IW     = 4 + 3 * ADDR_W,
  localparam int DEPTH  = 1 << ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [IW-1:0]           instruction,
  output logic [DATA_W*DEPTH-1:0] memory,
  output logic [DATA_W-1:0]       r1,
  output logic [DATA_W-1:0]       r2,
  output logic [DATA_W-1:0]       r3,
  output logic                    done,
  output logic                    carry,
  output logic                    div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1
`ifdef MEM_ALU_MULDIV_EN
    , S_DIV = 2'd2
`endif
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [3:0]          r_op;
  logic [ADDR_W-1:0]   r_d;
  logic [2*ADDR_W-1:0] r_imm;

  logic [3:0]          w_f_op;
  logic [ADDR_W-1:0]   w_f_a, w_f_b, w_f_d;
  logic [2*ADDR_W-1:0] w_f_imm;
  logic [DATA_W-1:0]   w_imm_ext;
  logic [DATA_W-1:0]   w_res;
  logic                w_wen, w_cy_we, w_cy, w_dz;

  assign w_f_op  = instruction[IW-1 -: 4];
  assign w_f_a   = instruction[3*ADDR_W-1 -: ADDR_W];
  assign w_f_b   = instruction[2*ADDR_W-1 -: ADDR_W];
  assign w_f_d   = instruction[ADDR_W-1:0];
  assign w_f_imm = instruction[3*ADDR_W-1:ADDR_W];

  assign instr_ready = (r_state == S_IDLE);

  generate
    if (2 * ADDR_W >= DATA_W) begin : g_imm_trunc
      assign w_imm_ext = r_imm[DATA_W-1:0];
    end else begin : g_imm_zext
      assign w_imm_ext = {{(DATA_W - 2*ADDR_W){1'b0}}, r_imm};
    end
  endgenerate

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_mem_flat
      assign memory[k*DATA_W +: DATA_W] = r_mem[k];
    end
  endgenerate

`ifdef MEM_ALU_MULDIV_EN
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_quo, r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W:0]   w_rem_sh;
  logic              w_ge, w_div_last, w_start_div;
  logic [DATA_W-1:0] w_rem_nxt, w_quo_nxt, w_div_res;

  // Restoring step: shift next dividend bit into the partial remainder,
  // subtract the divisor when it fits. r2 is stable for the whole division.
  assign w_rem_sh   = {r_rem, r_quo[DATA_W-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r2});
  assign w_rem_nxt  = w_ge ? (w_rem_sh[DATA_W-1:0] - r2) : w_rem_sh[DATA_W-1:0];
  assign w_quo_nxt  = {r_quo[DATA_W-2:0], w_ge};
  assign w_div_last = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_div_res  = r_op[0] ? w_rem_nxt : w_quo_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_res       = r3;
    w_wen       = 1'b0;
    w_cy_we     = 1'b0;
    w_cy        = carry;
    w_dz        = 1'b0;
`ifdef MEM_ALU_MULDIV_EN
    w_start_div = 1'b0;
`endif
    case (r_op)
      4'd0:  begin w_res = w_imm_ext;                                w_wen = 1'b1; end
      4'd1:  begin w_res = {{(DATA_W-1){1'b0}}, (r2 == r1)};         w_wen = 1'b1; end
      4'd2:  begin w_res = {{(DATA_W-1){1'b0}}, (r2 <  r1)};         w_wen = 1'b1; end
      4'd3:  begin w_res = {{(DATA_W-1){1'b0}}, (r2 <= r1)};         w_wen = 1'b1; end
      4'd4:  begin w_res = r1 | r2;                                  w_wen = 1'b1; end
      4'd8:  begin w_res = r1 & r2;                                  w_wen = 1'b1; end
      4'd9:  begin w_res = r1 ^ r2;                                  w_wen = 1'b1; end
      4'd10: begin w_res = ~r1;                                      w_wen = 1'b1; end
      4'd11: begin
        {w_cy, w_res} = {1'b0, r1} + {1'b0, r2};
        w_wen   = 1'b1;
        w_cy_we = 1'b1;
      end
      4'd12: begin
        w_res   = r1 - r2;
        w_cy    = (r1 < r2);
        w_wen   = 1'b1;
        w_cy_we = 1'b1;
      end
`ifdef MEM_ALU_MULDIV_EN
      4'd13: begin w_res = r1 * r2; w_wen = 1'b1; end
      4'd14, 4'd15: begin
        if (r2 == '0) begin
          w_res = r_op[0] ? r1 : {DATA_W{1'b1}};
          w_wen = 1'b1;
          w_dz  = 1'b1;
        end else begin
          w_start_div = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    case (r_state)
      S_IDLE: if (instr_valid) w_state_nxt = S_EXEC;
`ifdef MEM_ALU_MULDIV_EN
      S_EXEC: w_state_nxt = w_start_div ? S_DIV : S_IDLE;
      S_DIV:  if (w_div_last) w_state_nxt = S_IDLE;
`else
      S_EXEC: w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_op     <= '0;
      r_d      <= '0;
      r_imm    <= '0;
      r1       <= '0;
      r2       <= '0;
      r3       <= '0;
      done     <= 1'b0;
      carry    <= 1'b0;
      div_zero <= 1'b0;
`ifdef MEM_ALU_MULDIV_EN
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op  <= w_f_op;
            r_d   <= w_f_d;
            r_imm <= w_f_imm;
            r1    <= r_mem[w_f_a];
            r2    <= r_mem[w_f_b];
          end
        end
        S_EXEC: begin
          if (w_wen) begin
            r_mem[r_d] <= w_res;
            r3         <= w_res;
          end
          if (w_cy_we) carry <= w_cy;
`ifdef MEM_ALU_MULDIV_EN
          if (w_start_div) begin
            r_quo <= r1;
            r_rem <= '0;
            r_cnt <= '0;
          end else begin
            done     <= 1'b1;
            div_zero <= w_dz;
          end
`else
          done     <= 1'b1;
          div_zero <= w_dz;
`endif
        end
`ifdef MEM_ALU_MULDIV_EN
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_div_last) begin
            r_mem[r_d] <= w_div_res;
            r3         <= w_div_res;
            done       <= 1'b1;
            div_zero   <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
